// File: rtl/cla_pkg.sv
// Shared constants for the pipelined carry-lookahead adder: group width,
// operation encoding and the parameter legality rule.
package cla_pkg;

  localparam int GROUP_W = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // WIDTH must be whole groups; STAGES must split the groups evenly.
  function automatic bit params_ok(input int width, input int stages);
    if (width < GROUP_W || (width % GROUP_W) != 0) return 1'b0;
    if (stages < 1 || stages > width / GROUP_W) return 1'b0;
    return ((width / GROUP_W) % stages) == 0;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// One 4-bit carry-lookahead group: sum bits plus group generate/propagate
// for the lookahead network above it.
module cla_slice
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               ci,
  output logic [GROUP_W-1:0] y,
  output logic               g,
  output logic               p
);

  logic [GROUP_W-1:0] gen;
  logic [GROUP_W-1:0] prop;
  logic [GROUP_W-1:0] c;

  assign gen  = a & b;
  assign prop = a ^ b;

  // Every internal carry is a flat function of ci, so no ripple inside the group.
  assign c[0] = ci;
  assign c[1] = gen[0] | (prop[0] & ci);
  assign c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & ci);
  assign c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
              | (prop[2] & prop[1] & prop[0] & ci);

  assign y = prop ^ c;
  assign g = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
           | (prop[3] & prop[2] & prop[1] & gen[0]);
  assign p = &prop;

endmodule

// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Each stage resolves a run of 4-bit groups; carry and unresolved operands move on.
module cla_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             co,
  output logic             ovf
);

  localparam int NG  = WIDTH / GROUP_W;
  localparam int GPS = (STAGES > 0) ? NG / STAGES : 1;
  localparam int SW  = GPS * GROUP_W;

  if (!params_ok(WIDTH, STAGES)) begin : g_param_check
    $error("cla_pipe: illegal WIDTH=%0d / STAGES=%0d", WIDTH, STAGES);
  end

  logic adv;

  // Per-stage inputs: index 0 comes from the ports, later ones from stage registers.
  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] y_in [STAGES];
  logic             c_in [STAGES];
  logic             v_in [STAGES];
  logic [WIDTH-1:0] y_st [STAGES];
  logic             c_st [STAGES];

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign a_in[0] = a;
  assign b_in[0] = (sub == OP_SUB) ? ~b : b;
  assign c_in[0] = (sub == OP_SUB) ? 1'b1 : ci;
  assign y_in[0] = '0;
  assign v_in[0] = in_valid;

  genvar gi, gj;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [GPS-1:0]   grp_g;
      logic [GPS-1:0]   grp_p;
      logic [GPS:0]     grp_c;
      logic [SW-1:0]    sum;
      logic [WIDTH-1:0] y_next;

      for (gj = 0; gj < GPS; gj++) begin : g_group
        cla_slice u_slice (
          .a  (a_in[gi][(gi*GPS+gj)*GROUP_W +: GROUP_W]),
          .b  (b_in[gi][(gi*GPS+gj)*GROUP_W +: GROUP_W]),
          .ci (grp_c[gj]),
          .y  (sum[gj*GROUP_W +: GROUP_W]),
          .g  (grp_g[gj]),
          .p  (grp_p[gj])
        );
      end

      // Two-level lookahead: each group carry is a sum of products of g/p terms.
      always_comb begin
        logic acc;
        logic term;
        acc      = 1'b0;
        term     = 1'b0;
        grp_c    = '0;
        grp_c[0] = c_in[gi];
        for (int k = 0; k < GPS; k++) begin
          acc = c_in[gi];
          for (int j = 0; j <= k; j++) acc = acc & grp_p[j];
          for (int j = 0; j <= k; j++) begin
            term = grp_g[j];
            for (int m = j + 1; m <= k; m++) term = term & grp_p[m];
            acc = acc | term;
          end
          grp_c[k+1] = acc;
        end
      end

      always_comb begin
        y_next = y_in[gi];
        y_next[gi*SW +: SW] = sum;
      end

      assign y_st[gi] = y_next;
      assign c_st[gi] = grp_c[GPS];

      if (gi < STAGES - 1) begin : g_mid
        localparam int LO_W = (gi + 1) * SW;
        localparam int HI_W = WIDTH - LO_W;

        logic [HI_W-1:0] a_hi_reg;
        logic [HI_W-1:0] b_hi_reg;
        logic [LO_W-1:0] y_lo_reg;
        logic            c_reg;
        logic            v_reg;

        // Upper operand bits wait for their stage; resolved sum bits wait for the rest.
        always_ff @(posedge clk) begin
          if (rst) begin
            a_hi_reg <= '0;
            b_hi_reg <= '0;
            y_lo_reg <= '0;
            c_reg    <= 1'b0;
            v_reg    <= 1'b0;
          end else if (adv) begin
            a_hi_reg <= a_in[gi][WIDTH-1:LO_W];
            b_hi_reg <= b_in[gi][WIDTH-1:LO_W];
            y_lo_reg <= y_st[gi][LO_W-1:0];
            c_reg    <= c_st[gi];
            v_reg    <= v_in[gi];
          end
        end

        assign a_in[gi+1] = {a_hi_reg, {LO_W{1'b0}}};
        assign b_in[gi+1] = {b_hi_reg, {LO_W{1'b0}}};
        assign y_in[gi+1] = {{HI_W{1'b0}}, y_lo_reg};
        assign c_in[gi+1] = c_reg;
        assign v_in[gi+1] = v_reg;
      end else begin : g_last
        logic [WIDTH-1:0] y_reg;
        logic             co_reg;
        logic             ovf_reg;
        logic             v_reg;

        always_ff @(posedge clk) begin
          if (rst) begin
            y_reg   <= '0;
            co_reg  <= 1'b0;
            ovf_reg <= 1'b0;
            v_reg   <= 1'b0;
          end else if (adv) begin
            y_reg   <= y_st[gi];
            co_reg  <= c_st[gi];
            ovf_reg <= (a_in[gi][WIDTH-1] == b_in[gi][WIDTH-1])
                    && (y_st[gi][WIDTH-1] != a_in[gi][WIDTH-1]);
            v_reg   <= v_in[gi];
          end
        end

        assign y         = y_reg;
        assign co        = co_reg;
        assign ovf       = ovf_reg;
        assign out_valid = v_reg;
      end
    end
  endgenerate

endmodule

// File: tb/tb_cla_pipe.sv
// Directed bench for cla_pipe: a 16-bit/4-stage instance for flow control and
// arithmetic, plus 32/1 and 8/2 builds for latency and value checks.
module tb_cla_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, out_ready, ci, sub;
  logic [15:0] a, b;
  logic        in_ready, out_valid, co, ovf;
  logic [15:0] y;

  logic        in_valid32, out_ready32, ci32, sub32;
  logic [31:0] a32, b32;
  logic        in_ready32, out_valid32, co32, ovf32;
  logic [31:0] y32;

  logic        in_valid8, out_ready8, ci8, sub8;
  logic [7:0]  a8, b8;
  logic        in_ready8, out_valid8, co8, ovf8;
  logic [7:0]  y8;

  cla_pipe #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .y(y), .co(co), .ovf(ovf)
  );

  cla_pipe #(.WIDTH(32), .STAGES(1)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32), .a(a32), .b(b32),
    .ci(ci32), .sub(sub32), .out_valid(out_valid32), .out_ready(out_ready32), .y(y32),
    .co(co32), .ovf(ovf32)
  );

  cla_pipe #(.WIDTH(8), .STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .ci(ci8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8), .y(y8),
    .co(co8), .ovf(ovf8)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] va [32];
  logic [15:0] vb [32];
  logic        vci [32];
  logic        vsub [32];
  int          n_vec;

  logic [15:0] cy [64];
  logic        cco [64];
  logic        covf [64];
  int          ccyc [64];
  int          n_cap, hold_bad, held_n, acc_snap;

  // Returns {ovf, co, y[31:0]} for a w-bit operation.
  function automatic logic [33:0] model(input int w, input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mci, input logic msub);
    logic [32:0] mask, bx, s;
    logic [31:0] yy;
    logic        cc, oo;
    mask = (33'd1 << w) - 33'd1;
    bx   = msub ? (~{1'b0, mb}) & mask : {1'b0, mb} & mask;
    s    = ({1'b0, ma} & mask) + bx + (msub ? 33'd1 : {32'd0, mci});
    yy   = s[31:0] & mask[31:0];
    cc   = s[w];
    oo   = (ma[w-1] == bx[w-1]) && (yy[w-1] != ma[w-1]);
    return {oo, cc, yy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input int n);
    n_vec = n;
    for (int i = 0; i < n; i++) begin
      va[i]   = 16'($urandom);
      vb[i]   = 16'($urandom);
      vci[i]  = 1'($urandom);
      vsub[i] = 1'($urandom);
    end
  endtask

  // Drives one transaction and waits (bounded) for its result.
  task automatic run_one(input logic [15:0] ta, input logic [15:0] tb, input logic tci,
                         input logic tsub, output logic [15:0] ry, output logic rco,
                         output logic rovf, output int lat);
    a = ta; b = tb; ci = tci; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    ry = y; rco = co; rovf = ovf;
    tick();
  endtask

  // Streams va/vb through the main DUT, capturing every delivered result.
  task automatic stream(input int ncyc, input int sf, input int st, input int vmode, input int rmode);
    int k;
    logic held_prev;
    logic [15:0] py;
    logic pco, povf;
    k = 0; n_cap = 0; hold_bad = 0; held_n = 0; acc_snap = -1;
    held_prev = 1'b0; py = '0; pco = 1'b0; povf = 1'b0;
    for (int t = 0; t < ncyc; t++) begin
      out_ready = (rmode == 0) ? !(t >= sf && t < st) : ((t % 3) != 2);
      in_valid  = (k < n_vec) && (vmode == 0 || (t % 2) == 0);
      if (k < n_vec) begin
        a = va[k]; b = vb[k]; ci = vci[k]; sub = vsub[k];
      end else begin
        a = 16'($urandom); b = 16'($urandom); ci = 1'b0; sub = 1'b0;
      end
      #1;
      if (t == st) acc_snap = k;
      if (out_valid && !out_ready) begin
        held_n++;
        if (in_ready) hold_bad++;
        if (held_prev && (y !== py || co !== pco || ovf !== povf)) hold_bad++;
      end
      held_prev = out_valid && !out_ready;
      py = y; pco = co; povf = ovf;
      if (out_valid && out_ready && n_cap < 64) begin
        cy[n_cap] = y; cco[n_cap] = co; covf[n_cap] = ovf; ccyc[n_cap] = t;
        n_cap++;
      end
      if (in_valid && in_ready) k++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    in_valid32 = 1'b0; out_ready32 = 1'b1; a32 = '0; b32 = '0; ci32 = 1'b0; sub32 = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; ci8 = 1'b0; sub8 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if ({ovf, co, y} !== 18'h0) begin errors++; $display("FAIL reset_data got %h want 0", {ovf, co, y}); end
    checks++; if ({out_valid32, out_valid8} !== 2'b00) begin errors++; $display("FAIL reset_aux_valid got %b want 00", {out_valid32, out_valid8}); end
    checks++; if ({y32, y8} !== 40'h0) begin errors++; $display("FAIL reset_aux_y got %h want 0", {y32, y8}); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    logic [15:0] ry;
    logic rco, rovf;
    int lat;
    run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, ry, rco, rovf, lat);
    $display("latency txn: lat=%0d y=%h co=%b ovf=%b", lat, ry, rco, rovf);
    checks++; if (lat != 4) begin errors++; $display("FAIL latency got %0d want 4", lat); end
    checks++; if ({rovf, rco, ry} !== {1'b0, 1'b1, 16'h0000}) begin
      errors++; $display("FAIL wrap_add got ovf=%b co=%b y=%h want 0 1 0000", rovf, rco, ry);
    end
  endtask

  task automatic test_directed();
    logic [15:0] ta [8] = '{16'h8000, 16'h0000, 16'h7FFF, 16'h1234, 16'h0005, 16'h0FFF, 16'hFFFF, 16'h8000};
    logic [15:0] tb [8] = '{16'h0001, 16'h0001, 16'h0001, 16'h4321, 16'h0003, 16'h0001, 16'hFFFF, 16'h8000};
    logic        tci [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        tsb [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] ey [8] = '{16'h7FFF, 16'hFFFF, 16'h8000, 16'h5556, 16'h0002, 16'h1000, 16'hFFFF, 16'h0000};
    logic        eco [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        eov [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] ry;
    logic rco, rovf;
    int lat;
    for (int i = 0; i < 8; i++) begin
      run_one(ta[i], tb[i], tci[i], tsb[i], ry, rco, rovf, lat);
      $display("directed %0d: a=%h b=%h ci=%b sub=%b -> y=%h co=%b ovf=%b", i, ta[i], tb[i], tci[i], tsb[i], ry, rco, rovf);
      checks++; if ({rovf, rco, ry} !== {eov[i], eco[i], ey[i]}) begin
        errors++; $display("FAIL directed_%0d got ovf=%b co=%b y=%h want %b %b %h", i, rovf, rco, ry, eov[i], eco[i], ey[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] m;
    fill_random(16);
    stream(40, 0, 0, 0, 0);
    checks++; if (n_cap != 16) begin errors++; $display("FAIL b2b_count got %0d want 16", n_cap); end
    for (int i = 0; i < 16 && i < n_cap; i++) begin
      m = model(16, {16'h0, va[i]}, {16'h0, vb[i]}, vci[i], vsub[i]);
      $display("b2b %0d: cycle=%0d y=%h co=%b ovf=%b", i, ccyc[i], cy[i], cco[i], covf[i]);
      checks++; if ({covf[i], cco[i], cy[i]} !== {m[33], m[32], m[15:0]}) begin
        errors++; $display("FAIL b2b_%0d got %h want %h", i, {covf[i], cco[i], cy[i]}, {m[33], m[32], m[15:0]});
      end
    end
    if (n_cap == 16) begin
      checks++; if (ccyc[0] != 4 || ccyc[15] - ccyc[0] != 15) begin
        errors++; $display("FAIL b2b_timing got first=%0d last=%0d want 4 19", ccyc[0], ccyc[15]);
      end
    end
  endtask

  task automatic test_stall();
    logic [33:0] m;
    fill_random(8);
    stream(30, 0, 10, 0, 0);
    checks++; if (acc_snap != 4) begin errors++; $display("FAIL stall_accepted got %0d want 4", acc_snap); end
    checks++; if (held_n != 6) begin errors++; $display("FAIL stall_held_cycles got %0d want 6", held_n); end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL stall_hold got %0d violations want 0", hold_bad); end
    checks++; if (n_cap != 8) begin errors++; $display("FAIL stall_count got %0d want 8", n_cap); end
    for (int i = 0; i < 8 && i < n_cap; i++) begin
      m = model(16, {16'h0, va[i]}, {16'h0, vb[i]}, vci[i], vsub[i]);
      $display("stall %0d: cycle=%0d y=%h co=%b ovf=%b", i, ccyc[i], cy[i], cco[i], covf[i]);
      checks++; if ({covf[i], cco[i], cy[i]} !== {m[33], m[32], m[15:0]}) begin
        errors++; $display("FAIL stall_%0d got %h want %h", i, {covf[i], cco[i], cy[i]}, {m[33], m[32], m[15:0]});
      end
    end
    if (n_cap == 8) begin
      checks++; if (ccyc[0] != 10 || ccyc[7] != 17) begin
        errors++; $display("FAIL stall_drain got first=%0d last=%0d want 10 17", ccyc[0], ccyc[7]);
      end
    end
  endtask

  task automatic test_bubbles();
    logic [33:0] m;
    fill_random(10);
    stream(60, 0, 0, 1, 1);
    checks++; if (n_cap != 10) begin errors++; $display("FAIL bubble_count got %0d want 10", n_cap); end
    for (int i = 0; i < 10 && i < n_cap; i++) begin
      m = model(16, {16'h0, va[i]}, {16'h0, vb[i]}, vci[i], vsub[i]);
      $display("bubble %0d: cycle=%0d y=%h co=%b ovf=%b", i, ccyc[i], cy[i], cco[i], covf[i]);
      checks++; if ({covf[i], cco[i], cy[i]} !== {m[33], m[32], m[15:0]}) begin
        errors++; $display("FAIL bubble_%0d got %h want %h", i, {covf[i], cco[i], cy[i]}, {m[33], m[32], m[15:0]});
      end
    end
  endtask

  task automatic test_reset_midflight();
    int stale;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'h1111 * 16'(i + 1); b = 16'h0101; ci = 1'b1; sub = 1'b0; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    $display("midflight reset: out_valid=%b y=%h", out_valid, y);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid); end
    checks++; if ({ovf, co, y} !== 18'h0) begin errors++; $display("FAIL midrst_data got %h want 0", {ovf, co, y}); end
    rst = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL midrst_stale got %0d outputs want 0", stale); end
  endtask

  task automatic test_w32();
    logic [31:0] wa [40];
    logic [31:0] wb [40];
    logic        wci [40];
    logic        wsub [40];
    logic [33:0] m;
    for (int i = 0; i < 40; i++) begin
      wa[i] = $urandom; wb[i] = $urandom; wci[i] = 1'($urandom); wsub[i] = 1'($urandom);
    end
    wa[0] = 32'hFFFF_FFFF; wb[0] = 32'h1; wci[0] = 1'b0; wsub[0] = 1'b0;
    wa[1] = 32'h8000_0000; wb[1] = 32'h1; wci[1] = 1'b0; wsub[1] = 1'b1;
    out_ready32 = 1'b1;
    for (int t = 0; t <= 40; t++) begin
      checks++; if (out_valid32 !== (t >= 1)) begin errors++; $display("FAIL w32_valid_t%0d got %b want %b", t, out_valid32, t >= 1); end
      if (t >= 1) begin
        m = model(32, wa[t-1], wb[t-1], wci[t-1], wsub[t-1]);
        $display("w32 %0d: y=%h co=%b ovf=%b", t - 1, y32, co32, ovf32);
        checks++; if ({ovf32, co32, y32} !== m) begin errors++; $display("FAIL w32_%0d got %h want %h", t - 1, {ovf32, co32, y32}, m); end
      end
      if (t == 1) begin
        checks++; if ({ovf32, co32, y32} !== {2'b01, 32'h0}) begin errors++; $display("FAIL w32_wrap got %h want %h", {ovf32, co32, y32}, {2'b01, 32'h0}); end
      end
      if (t == 2) begin
        checks++; if ({ovf32, co32, y32} !== {2'b11, 32'h7FFF_FFFF}) begin errors++; $display("FAIL w32_subovf got %h want %h", {ovf32, co32, y32}, {2'b11, 32'h7FFF_FFFF}); end
      end
      in_valid32 = (t < 40);
      if (t < 40) begin a32 = wa[t]; b32 = wb[t]; ci32 = wci[t]; sub32 = wsub[t]; end
      tick();
    end
    in_valid32 = 1'b0;
  endtask

  task automatic test_w8();
    logic [7:0]  ea [120];
    logic [7:0]  eb [120];
    logic        eci [120];
    logic        esub [120];
    logic [33:0] m;
    for (int i = 0; i < 120; i++) begin
      ea[i] = 8'($urandom); eb[i] = 8'($urandom); eci[i] = 1'($urandom); esub[i] = 1'($urandom);
    end
    ea[0] = 8'hFF; eb[0] = 8'h01; eci[0] = 1'b0; esub[0] = 1'b0;
    ea[1] = 8'h80; eb[1] = 8'h01; eci[1] = 1'b0; esub[1] = 1'b1;
    out_ready8 = 1'b1;
    for (int t = 0; t <= 121; t++) begin
      checks++; if (out_valid8 !== (t >= 2)) begin errors++; $display("FAIL w8_valid_t%0d got %b want %b", t, out_valid8, t >= 2); end
      if (t >= 2) begin
        m = model(8, {24'h0, ea[t-2]}, {24'h0, eb[t-2]}, eci[t-2], esub[t-2]);
        $display("w8 %0d: y=%h co=%b ovf=%b", t - 2, y8, co8, ovf8);
        checks++; if ({ovf8, co8, y8} !== {m[33], m[32], m[7:0]}) begin
          errors++; $display("FAIL w8_%0d got %h want %h", t - 2, {ovf8, co8, y8}, {m[33], m[32], m[7:0]});
        end
      end
      if (t == 2) begin
        checks++; if ({ovf8, co8, y8} !== 10'b01_0000_0000) begin errors++; $display("FAIL w8_wrap got %b want 0100000000", {ovf8, co8, y8}); end
      end
      if (t == 3) begin
        checks++; if ({ovf8, co8, y8} !== 10'b11_0111_1111) begin errors++; $display("FAIL w8_subovf got %b want 1101111111", {ovf8, co8, y8}); end
      end
      in_valid8 = (t < 120);
      if (t < 120) begin a8 = ea[t]; b8 = eb[t]; ci8 = eci[t]; sub8 = esub[t]; end
      tick();
    end
    in_valid8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_back_to_back();
    test_stall();
    test_bubbles();
    test_reset_midflight();
    test_w32();
    test_w8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired after 1000000 time units");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cla_pipe.md
CLA_PIPE -- requirements
Module: cla_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; SHALL be a multiple of 4, minimum 4.
REQ-002 Parameter STAGES, default 2, pipeline depth; SHALL divide WIDTH/4 exactly, range 1..WIDTH/4.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operands present this cycle.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 ci  input  1  carry-in; ignored when sub=1.
REQ-010 sub  input  1  0 = add, 1 = subtract (A - B).
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 y  output  WIDTH  sum/difference.
REQ-014 co  output  1  carry-out; for sub=1, 1 = no borrow.
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Arithmetic SHALL be {co,y} = A + B' + c0, with B' = sub ? ~B : B and c0 = sub ? 1 : ci, modulo 2^(WIDTH+1).
REQ-017 ovf SHALL be (A[msb] == B'[msb]) && (y[msb] != A[msb]).
REQ-018 Operands SHALL be split into WIDTH/4 four-bit groups; each stage resolves (WIDTH/4)/STAGES consecutive groups, low groups first, using group generate/propagate lookahead within the stage.
REQ-019 Inter-stage carry SHALL be registered; unresolved upper operand bits SHALL be delayed (skew) and resolved lower sum bits SHALL be delayed (deskew) so a transaction's bits leave together.
REQ-020 Latency SHALL be exactly STAGES cycles from an accepted input (in_valid && in_ready) to out_valid for that transaction when out_ready stays 1.
REQ-021 Pipeline advance enable adv = !out_valid || out_ready; in_ready SHALL equal adv, combinationally.
REQ-022 When adv=0 every stage register, including valid bits, SHALL hold; y/co/ovf SHALL remain stable while out_valid && !out_ready.
REQ-023 Bubbles SHALL propagate as invalid slots; no bubble collapsing. Throughput SHALL be one transaction per cycle with out_ready=1.
REQ-024 Transactions SHALL leave in acceptance order; none dropped or duplicated under any in_valid/out_ready pattern.
REQ-025 in_valid with in_ready=0 SHALL NOT be accepted; operands need not be held by the block.
REQ-026 Simultaneous output handshake and input acceptance in one cycle SHALL be legal and lossless.
REQ-027 STAGES=1 SHALL yield a single registered output stage, latency 1.

Reset
REQ-028 While rst=1 at a clk edge, all stage valid bits SHALL clear; out_valid SHALL be 0 the following cycle.
REQ-029 After reset y, co, ovf and all data registers SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight transactions; none SHALL appear afterwards.
REQ-031 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-032 A shared package cla_pkg SHALL hold GROUP_W = 4 and the op encoding (OP_ADD = 0, OP_SUB = 1).
REQ-033 One sub-module cla_slice SHALL implement a 4-bit group: inputs a, b, ci; outputs y, group g, group p; cla_pipe SHALL instantiate WIDTH/4 of them plus per-stage lookahead.
REQ-034 Parameter legality (REQ-001, REQ-002) SHALL be checked at elaboration and fail on violation.

Verification (WIDTH=16, STAGES=4 unless noted)
REQ-035 a=0xFFFF, b=0x0001, ci=0, sub=0, out_ready=1 -> exactly 4 cycles later y=0x0000, co=1, ovf=0.
REQ-036 a=0x8000, b=0x0001, sub=1 -> y=0x7FFF, co=1, ovf=1; a=0x0000, b=0x0001, sub=1 -> y=0xFFFF, co=0, ovf=0.
REQ-037 Back-to-back 16 random transactions, out_ready=1 -> 16 results on 16 consecutive cycles, in order, matching the reference model.
REQ-038 out_ready=0 while streaming -> in_ready falls once out_valid=1, 4 transactions held stable; release -> all drain in order, none lost.
REQ-039 rst pulsed with 3 transactions in flight -> out_valid=0 next cycle, no stale results ever emitted, y=0.
REQ-040 WIDTH=32, STAGES=1 and WIDTH=8, STAGES=2 builds -> exhaustive/random compare against (A + B' + c0), latency 1 and 2 respectively.
